// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I encodings for the memory stage
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT_R
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores, load extraction and misalign detection
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0, w_half};
            F3_W:    o_rdata = i_rdata;
            default: o_rdata = 32'h0;
        endcase
    end

    // Store size comes from funct3[1:0] only; bit 2 is meaningless for stores.
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_lane[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_lane[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_lane != 2'b00));

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I M stage with data-memory handshake and MEM/WB register
module memory_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ValidM,
    input  logic                      RegWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic                      MemWriteM,
    input  logic [2:0]                Funct3M,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    input  logic [DATA_WIDTH-1:0]     PCPlus4M,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    output logic                      StallM,
    output logic                      DMemReq,
    output logic                      DMemWe,
    output logic [DATA_WIDTH-1:0]     DMemAddr,
    output logic [DATA_WIDTH-1:0]     DMemWData,
    output logic [3:0]                DMemBe,
    input  logic                      DMemGnt,
    input  logic                      DMemRValid,
    input  logic [DATA_WIDTH-1:0]     DMemRData,
    output logic                      RegWriteW,
    output logic [1:0]                ResultSrcW,
    output logic [DATA_WIDTH-1:0]     ALUResultW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [DATA_WIDTH-1:0]     PCPlus4W,
    output logic [REG_ADDR_WIDTH-1:0] RdW,
    output logic                      MisalignW
);

    mem_state_t r_state;

    logic                  w_is_load;
    logic                  w_is_mem;
    logic                  w_mis_raw;
    logic                  w_mis;
    logic                  w_memop;
    logic [DATA_WIDTH-1:0] w_load_data;

    load_store_align u_align (
        .i_funct3   (Funct3M),
        .i_lane     (ALUResultM[1:0]),
        .i_wdata    (WriteDataM),
        .i_rdata    (DMemRData),
        .o_be       (DMemBe),
        .o_wdata    (DMemWData),
        .o_rdata    (w_load_data),
        .o_misalign (w_mis_raw)
    );

    // A misaligned access never reaches the bus; it just tags the W slot.
    assign w_is_load = (ResultSrcM == RES_MEM);
    assign w_is_mem  = ValidM && (MemWriteM || w_is_load);
    assign w_mis     = w_is_mem && w_mis_raw;
    assign w_memop   = w_is_mem && !w_mis_raw;

    assign DMemReq  = (r_state == IDLE) && w_memop;
    assign DMemWe   = MemWriteM && DMemReq;
    assign DMemAddr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign StallM   = (r_state == IDLE) ? (w_memop && (w_is_load || !DMemGnt))
                                        : !DMemRValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            MisalignW  <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (w_memop && w_is_load && DMemGnt) r_state <= WAIT_R;
                WAIT_R:  if (DMemRValid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Stalled cycles push a bubble so writeback never repeats a write.
            if (StallM) begin
                RegWriteW <= 1'b0;
                MisalignW <= 1'b0;
            end else begin
                RegWriteW  <= ValidM && RegWriteM && !w_mis;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                PCPlus4W   <= PCPlus4M;
                RdW        <= RdM;
                MisalignW  <= w_mis;
                if (r_state == WAIT_R) ReadDataW <= w_load_data;
            end
        end
    end

endmodule
